// File: rtl/weight_sched_pkg.sv
// rtl/weight_sched_pkg.sv - shared state encoding and width defaults for the weight route scheduler
package weight_sched_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        WAIT_PE = 3'd3,
        STREAM  = 3'd4,
        REUSE   = 3'd5,
        NEXT    = 3'd6,
        DONE    = 3'd7
    } sched_state_e;

endpackage

// File: rtl/weight_route_scheduler.sv
// rtl/weight_route_scheduler.sv - walks G kernel groups: clear, load once from SRAM, stream R times
module weight_route_scheduler
    import weight_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_offset,
    input  logic [ADDR_WIDTH-1:0] i_route_size,
    input  logic [CNT_WIDTH-1:0]  i_num_groups,
    input  logic [CNT_WIDTH-1:0]  i_num_reuse,
    input  logic                  i_pe_ready,
    input  logic                  i_route_ready,
    input  logic                  i_route_done,
    output logic                  o_reg_clear,
    output logic                  o_fifo_clear,
    output logic                  o_route_en,
    output logic                  o_data_out_en,
    output logic                  o_route_reuse,
    output logic [ADDR_WIDTH-1:0] o_start_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_offset,
    output logic [ADDR_WIDTH-1:0] o_route_size,
    output logic [CNT_WIDTH-1:0]  o_group_idx,
    output logic [CNT_WIDTH-1:0]  o_reuse_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
);

    sched_state_e          state_q, state_d;
    logic                  abort_q, abort_d;
    logic                  first_q, first_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, off_q, off_d, size_q, size_d;
    logic [CNT_WIDTH-1:0]  grp_q, grp_d, rsu_q, rsu_d, ng_q, ng_d, nr_q, nr_d;
    logic [CNT_WIDTH:0]    grp_inc, rsu_inc;

    // One extra bit so G or R of all-ones still compares correctly after the increment
    assign grp_inc = {1'b0, grp_q} + 1'b1;
    assign rsu_inc = {1'b0, rsu_q} + 1'b1;

    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        first_d = first_q;
        err_d   = err_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        grp_d   = grp_q;
        rsu_d   = rsu_q;
        ng_d    = ng_q;
        nr_d    = nr_q;
        if (i_abort && state_q != IDLE) begin
            state_d = CLEAR;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    off_d  = i_addr_offset;
                    size_d = i_route_size;
                    ng_d   = i_num_groups;
                    nr_d   = i_num_reuse;
                    if (i_num_groups == '0 || i_num_reuse == '0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        grp_d   = '0;
                        rsu_d   = '0;
                        addr_d  = i_base_addr;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    state_d = abort_q ? IDLE : LOAD;
                    first_d = 1'b1;
                end
                LOAD: begin
                    first_d = 1'b0;
                    // Router load-complete is stale for one cycle after the clear
                    if (!first_q && i_route_ready) state_d = WAIT_PE;
                end
                WAIT_PE: if (i_pe_ready) state_d = STREAM;
                STREAM: if (i_route_done) begin
                    rsu_d   = rsu_inc[CNT_WIDTH-1:0];
                    state_d = (rsu_inc < {1'b0, nr_q}) ? REUSE : NEXT;
                end
                REUSE: state_d = WAIT_PE;
                NEXT: begin
                    rsu_d   = '0;
                    grp_d   = grp_inc[CNT_WIDTH-1:0];
                    addr_d  = addr_q + off_q + ADDR_WIDTH'(1);
                    state_d = (grp_inc < {1'b0, ng_q}) ? CLEAR : DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            abort_q       <= 1'b0;
            first_q       <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= '0;
            off_q         <= '0;
            size_q        <= '0;
            grp_q         <= '0;
            rsu_q         <= '0;
            ng_q          <= '0;
            nr_q          <= '0;
            o_reg_clear   <= 1'b0;
            o_fifo_clear  <= 1'b0;
            o_route_en    <= 1'b0;
            o_data_out_en <= 1'b0;
            o_route_reuse <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_q       <= state_d;
            abort_q       <= abort_d;
            first_q       <= first_d;
            err_q         <= err_d;
            addr_q        <= addr_d;
            off_q         <= off_d;
            size_q        <= size_d;
            grp_q         <= grp_d;
            rsu_q         <= rsu_d;
            ng_q          <= ng_d;
            nr_q          <= nr_d;
            o_reg_clear   <= (state_d == CLEAR);
            o_fifo_clear  <= (state_d == CLEAR);
            o_route_en    <= (state_d == LOAD);
            o_data_out_en <= (state_d == STREAM);
            o_route_reuse <= (state_d == REUSE);
            o_busy        <= (state_d != IDLE);
            o_done        <= (state_d == DONE);
        end
    end

    assign o_start_addr  = addr_q;
    assign o_addr_offset = off_q;
    assign o_route_size  = size_q;
    assign o_group_idx   = grp_q;
    assign o_reuse_idx   = rsu_q;
    assign o_cfg_err     = err_q;

endmodule
